// File: rtl/fu_pkg.sv
// fu_pkg: precision mode encodings and lane reduction shared by the MAC controller and array result path.
package fu_pkg;

    localparam logic [1:0] MODE_8X8 = 2'b00;
    localparam logic [1:0] MODE_4X4 = 2'b01;
    localparam logic [1:0] MODE_2X2 = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    function automatic logic [15:0] lane_sum(input logic [15:0] p, input logic [1:0] mode);
        return mode == MODE_8X8 ? p :
               mode == MODE_4X4 ? 16'(p[15:8]) + 16'(p[7:0]) :
               mode == MODE_2X2 ? 16'(p[15:12]) + 16'(p[11:8]) + 16'(p[7:4]) + 16'(p[3:0]) :
               16'd0;
    endfunction

endpackage

// File: rtl/gated_fu.sv
// gated_fu: precision-scalable multiplier; one 8x8, two 4x4 or four 2x2 lane products packed into 16 bits.
module gated_fu
    import fu_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] p_o
);

    logic [15:0] p8, p4, p2;

    assign p8 = 16'(a_i) * 16'(b_i);
    assign p4 = {8'(a_i[7:4]) * 8'(b_i[7:4]), 8'(a_i[3:0]) * 8'(b_i[3:0])};
    assign p2 = {4'(a_i[7:6]) * 4'(b_i[7:6]), 4'(a_i[5:4]) * 4'(b_i[5:4]),
                 4'(a_i[3:2]) * 4'(b_i[3:2]), 4'(a_i[1:0]) * 4'(b_i[1:0])};

    assign p_o = mode_i == MODE_8X8 ? p8 :
                 mode_i == MODE_4X4 ? p4 :
                 mode_i == MODE_2X2 ? p2 : '0;

endmodule

// File: rtl/fu_mac_ctrl.sv
// fu_mac_ctrl: three-stage dot-product sequencer around gated_fu with one buffered result per vector.
// Define FU_MAC_CTRL_SAT_EN to clamp the accumulator instead of wrapping.
module fu_mac_ctrl
    import fu_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_last,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [1:0]       res_mode,
    output logic [CNT_W-1:0] res_beats,
    output logic             res_err
);

    logic             alive_q, first_q;
    logic [1:0]       mode_q;
    logic             s1_valid_q, s1_last_q;
    logic [7:0]       s1_a_q, s1_b_q;
    logic [1:0]       s1_mode_q;
    logic             s2_valid_q, s2_last_q;
    logic [15:0]      s2_p_q;
    logic [1:0]       s2_mode_q;
    logic [ACC_W-1:0] acc_q, acc_d, acc_nx, lane;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d, err_nx, sat;
    logic             stall, accept, step, res_load;
    logic [15:0]      fu_p;

    assign stall    = s2_valid_q && s2_last_q && res_valid && !res_ready;
    assign in_ready = alive_q && !stall && !flush;
    assign accept   = in_valid && in_ready;
    assign step     = s2_valid_q && !stall && !flush;
    assign res_load = step && s2_last_q;

    // An empty S1 presents the gated mode so no multiplier lane toggles.
    gated_fu u_fu (
        .a_i   (s1_valid_q ? s1_a_q : 8'd0),
        .b_i   (s1_valid_q ? s1_b_q : 8'd0),
        .mode_i(s1_valid_q ? s1_mode_q : MODE_OFF),
        .p_o   (fu_p)
    );

    assign lane = ACC_W'(lane_sum(s2_p_q, s2_mode_q));

`ifdef FU_MAC_CTRL_SAT_EN
    logic [ACC_W:0] sum_w;
    assign sum_w  = {1'b0, acc_q} + {1'b0, lane};
    assign sat    = sum_w[ACC_W];
    assign acc_nx = sat ? '1 : sum_w[ACC_W-1:0];
`else
    assign sat    = 1'b0;
    assign acc_nx = acc_q + lane;
`endif

    assign err_nx = err_q || s2_mode_q == MODE_OFF || sat;

    always_comb begin
        acc_d = (flush || res_load) ? '0 : step ? acc_nx : acc_q;
        cnt_d = (flush || res_load) ? '0 : step ? cnt_q + CNT_W'(1) : cnt_q;
        err_d = (flush || res_load) ? 1'b0 : step ? err_nx : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q    <= 1'b0;
            first_q    <= 1'b1;
            mode_q     <= MODE_8X8;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_8X8;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_p_q     <= '0;
            s2_mode_q  <= MODE_8X8;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_mode   <= MODE_8X8;
            res_beats  <= '0;
            res_err    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (flush)
                first_q <= 1'b1;
            else if (accept)
                first_q <= in_last;
            if (accept && first_q)
                mode_q <= in_mode;
            if (flush)
                s1_valid_q <= 1'b0;
            else if (!stall)
                s1_valid_q <= accept;
            if (accept) begin
                s1_a_q    <= in_a;
                s1_b_q    <= in_b;
                s1_mode_q <= first_q ? in_mode : mode_q;
                s1_last_q <= in_last;
            end
            if (flush)
                s2_valid_q <= 1'b0;
            else if (!stall) begin
                s2_valid_q <= s1_valid_q;
                s2_p_q     <= fu_p;
                s2_mode_q  <= s1_mode_q;
                s2_last_q  <= s1_last_q;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (res_load) begin
                res_valid <= 1'b1;
                res_data  <= acc_nx;
                res_mode  <= s2_mode_q;
                res_beats <= cnt_q + CNT_W'(1);
                res_err   <= err_nx;
            end else if (res_ready)
                res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fu_mac_ctrl.sv
// tb_fu_mac_ctrl: directed vectors with a result scoreboard, run at ACC_W=16 so the overflow case is reachable.
module tb_fu_mac_ctrl;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [7:0]  n;
        logic        e;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, in_last, flush, res_valid, res_ready, res_err;
    logic [7:0]       in_a, in_b;
    logic [1:0]       in_mode, res_mode;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_beats;

    exp_t        sbq[$];
    exp_t        cur;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        held = 1'b0;
    logic [26:0] prev;

    fu_mac_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_mode(res_mode), .res_beats(res_beats), .res_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [15:0] d, input logic [1:0] m, input logic [7:0] n, input logic e);
        sbq.push_back('{d: d, m: m, n: n, e: e});
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = m;
        in_last = l;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    // Scoreboard monitor: compares every consumed result and checks hold stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n)
            held = 1'b0;
        else begin
            if (held)
                check("res_stable", {5'd0, res_data, res_mode, res_beats, res_err}, {5'd0, prev});
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got data %0d, required no result", res_data);
                end else begin
                    cur = sbq.pop_front();
                    check("result{data,mode,beats,err}", {5'd0, res_data, res_mode, res_beats, res_err},
                          {5'd0, cur.d, cur.m, cur.n, cur.e});
                end
            end
            held = res_valid && !res_ready;
            prev = {res_data, res_mode, res_beats, res_err};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
        in_last = 1'b0; flush = 1'b0; res_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_mode", res_mode, 0);
        check("rst_res_beats", res_beats, 0);
        check("rst_res_err", res_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        check("in_ready_after_reset", in_ready, 1);

        expect_res(16'd30000, 2'b00, 8'd1, 1'b0);
        beat(8'd200, 8'd150, 2'b00, 1'b1);
        idle(1);
        check("latency_edge_n1", res_valid, 0);
        idle(1);
        check("latency_edge_n2", res_valid, 1);
        drain();

        expect_res(16'd473, 2'b01, 8'd2, 1'b0);
        beat(8'h23, 8'h45, 2'b01, 1'b0);
        beat(8'hFF, 8'hFF, 2'b00, 1'b1);
        drain();

        expect_res(16'd36, 2'b10, 8'd1, 1'b0);
        beat(8'hFF, 8'hFF, 2'b10, 1'b1);
        expect_res(16'd0, 2'b11, 8'd1, 1'b1);
        beat(8'h12, 8'h34, 2'b11, 1'b1);
        drain();
        idle(2);

        res_ready = 1'b0;
        expect_res(16'd1, 2'b00, 8'd1, 1'b0);
        expect_res(16'd4, 2'b00, 8'd1, 1'b0);
        expect_res(16'd9, 2'b00, 8'd1, 1'b0);
        beat(8'd1, 8'd1, 2'b00, 1'b1);
        beat(8'd2, 8'd2, 2'b00, 1'b1);
        idle(3);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_res_valid", res_valid, 1);
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; in_mode = 2'b00; in_last = 1'b1;
        idle(3);
        check("bp_still_blocked", in_ready, 0);
        res_ready = 1'b1;
        beat(8'd3, 8'd3, 2'b00, 1'b1);
        drain();

`ifdef FU_MAC_CTRL_SAT_EN
        expect_res(16'd65535, 2'b00, 8'd3, 1'b1);
`else
        expect_res(16'd64003, 2'b00, 8'd3, 1'b0);
`endif
        beat(8'd255, 8'd255, 2'b00, 1'b0);
        beat(8'd255, 8'd255, 2'b00, 1'b0);
        beat(8'd255, 8'd255, 2'b00, 1'b1);
        drain();

        beat(8'd5, 8'd5, 2'b11, 1'b0);
        beat(8'd6, 8'd6, 2'b11, 1'b0);
        flush = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        idle(3);
        check("flush_no_result", res_valid, 0);
        expect_res(16'd9, 2'b00, 8'd1, 1'b0);
        beat(8'd3, 8'd3, 2'b00, 1'b1);
        drain();

        beat(8'd7, 8'd7, 2'b11, 1'b0);
        beat(8'd8, 8'd8, 2'b11, 1'b0);
        rst_n = 1'b0;
        #3 check("midrst_res_valid", res_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        check("midrst_no_result", res_valid, 0);
        expect_res(16'd9, 2'b00, 8'd1, 1'b0);
        beat(8'd3, 8'd3, 2'b00, 1'b1);
        drain();
        idle(3);

        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
